// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: word width, starvation
// counter width and the encoding of the previous cycle's access.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  // Kind of access granted on the previous cycle; decides who owns m_rdata now.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation guard for the display port: counts consecutive cycles in which
// port B requests but is refused, saturating at the counter maximum, and
// raises force_b once the count reaches STARVE_MAX.
module arb_starve_cnt
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
)
(
  input  logic clk,
  input  logic reset,
  input  logic b_req,
  input  logic b_gnt,
  output logic force_b
);

  logic [CNT_W-1:0] cnt;

  // Count refused B cycles; any B grant or idle B port restarts the count.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!b_req || b_gnt) begin
      cnt <= '0;
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_b = (cnt >= CNT_W'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core port A (read/write) and display port B
// (read-only) share one single-cycle memory. A has priority; with the macro
// DMEM_ARB_STARVE_EN defined, B is forced through after STARVE_MAX refused
// cycles. Read data returns exactly one cycle after the grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 4
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [WORD_W-1:0] a_addr,
  input  logic [WORD_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [WORD_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [WORD_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [WORD_W-1:0] b_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [WORD_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
);

  arb_state_t state;
  arb_state_t state_next;
  logic       force_b;
  logic       b_wins;

  // The memory works on word addresses; the byte-offset bits are dropped.
  logic [3:0] addr_lsb_unused;
  assign addr_lsb_unused = {a_addr[1:0], b_addr[1:0]};

`ifdef DMEM_ARB_STARVE_EN
  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk     (clk),
    .reset   (reset),
    .b_req   (b_req),
    .b_gnt   (b_gnt),
    .force_b (force_b)
  );
`else
  // Strict A-first priority: the threshold has no effect in this build.
  logic [CNT_W-1:0] starve_max_unused;
  assign starve_max_unused = CNT_W'(STARVE_MAX);
  assign force_b           = 1'b0;
`endif

  // Register the kind of access granted this cycle.
  // NOTE: the async reset is in the sensitivity list so state clears without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection, memory request muxing and read-data return steering.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    b_wins     = 1'b0;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    a_rvalid   = 1'b0;
    a_rdata    = '0;
    b_rvalid   = 1'b0;
    b_rdata    = '0;
    state_next = IDLE;

    // Holding reset silences every output at once, including in-flight reads.
    if (reset) begin
      b_wins = b_req && (!a_req || force_b);
      a_gnt  = a_req && !b_wins;
      b_gnt  = b_wins;

      if (a_gnt) begin
        m_en    = 1'b1;
        m_we    = a_we;
        m_addr  = {a_addr[WORD_W-1:2], 2'b00};
        m_wdata = a_wdata;
      end else if (b_gnt) begin
        m_en    = 1'b1;
        m_addr  = {b_addr[WORD_W-1:2], 2'b00};
      end

      unique case (state)
        RD_A: begin
          a_rvalid = 1'b1;
          a_rdata  = m_rdata;
        end
        RD_B: begin
          b_rvalid = 1'b1;
          b_rdata  = m_rdata;
        end
        default: ;
      endcase

      if (a_gnt && !a_we) begin
        state_next = RD_A;
      end else if (b_gnt) begin
        state_next = RD_B;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, starvation
// and reset-abort sequences, then randomized traffic against a reference model.
// Build with DMEM_ARB_STARVE_EN defined to exercise the forced-grant path.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req;
  logic [31:0] a_addr, a_wdata, b_addr, m_rdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, m_en, m_we;
  logic [31:0] a_rdata, b_rdata, m_addr, m_wdata;

  dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_addr   (b_addr),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: refused-B streak and who owns last cycle's read.
  int streak  = 0;
  int pending = 0;   // 0 none, 1 port A, 2 port B

  // Expected outputs, filled either from the table or from the model.
  logic        e_agnt, e_bgnt, e_men, e_mwe, e_arv, e_brv;
  logic [31:0] e_maddr, e_mwdata, e_ard, e_brd;

  typedef struct {
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        b_req;
    logic [31:0] b_addr;
    logic [31:0] m_rdata;
    logic        agnt;
    logic        bgnt;
    logic        men;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        arv;
    logic [31:0] ard;
    logic        brv;
    logic [31:0] brd;
    string       name;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".a_gnt"},    32'(a_gnt),    32'(e_agnt));
    check({tag, ".b_gnt"},    32'(b_gnt),    32'(e_bgnt));
    check({tag, ".m_en"},     32'(m_en),     32'(e_men));
    check({tag, ".m_we"},     32'(m_we),     32'(e_mwe));
    check({tag, ".m_addr"},   m_addr,        e_maddr);
    check({tag, ".m_wdata"},  m_wdata,       e_mwdata);
    check({tag, ".a_rvalid"}, 32'(a_rvalid), 32'(e_arv));
    check({tag, ".a_rdata"},  a_rdata,       e_ard);
    check({tag, ".b_rvalid"}, 32'(b_rvalid), 32'(e_brv));
    check({tag, ".b_rdata"},  b_rdata,       e_brd);
  endtask

  task automatic expect_all_zero();
    e_agnt = 1'b0; e_bgnt = 1'b0; e_men = 1'b0; e_mwe = 1'b0;
    e_maddr = '0; e_mwdata = '0; e_arv = 1'b0; e_ard = '0; e_brv = 1'b0; e_brd = '0;
  endtask

  // Arbitration rules applied to the currently driven inputs.
  task automatic model_expect();
    e_bgnt   = b_req && (!a_req || (STARVE_EN && streak >= SMAX));
    e_agnt   = a_req && !e_bgnt;
    e_men    = e_agnt || e_bgnt;
    e_mwe    = e_agnt && a_we;
    e_maddr  = e_agnt ? (a_addr & ~32'h3) : (e_bgnt ? (b_addr & ~32'h3) : 32'h0);
    e_mwdata = e_agnt ? a_wdata : 32'h0;
    e_arv    = (pending == 1);
    e_ard    = e_arv ? m_rdata : 32'h0;
    e_brv    = (pending == 2);
    e_brd    = e_brv ? m_rdata : 32'h0;
  endtask

  // Drive inputs mid-cycle and let combinational outputs settle.
  task automatic set_in(input logic ar, input logic awe, input logic [31:0] aad,
                        input logic [31:0] awd, input logic br, input logic [31:0] bad,
                        input logic [31:0] mr);
    @(negedge clk);
    a_req = ar; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = br; b_addr = bad; m_rdata = mr;
    #1;
  endtask

  // Advance the model by the access granted this cycle, then cross the edge.
  task automatic tick();
    logic g_a, g_b;
    model_expect();
    g_a = e_agnt;
    g_b = e_bgnt;
    if (b_req && !g_b) streak = (streak < 15) ? streak + 1 : 15;
    else               streak = 0;
    pending = (g_a && !a_we) ? 1 : (g_b ? 2 : 0);
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         a_req a_we  a_addr         a_wdata        b_req b_addr         m_rdata        agnt  bgnt  men   mwe   maddr          mwdata         arv   ard            brv   brd
    tbl[0]  = '{1'b1, 1'b0, 32'h00000010, 32'h00000000, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000010, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "a_rd"};
    tbl[1]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000, "a_rd_ret"};
    tbl[2]  = '{1'b1, 1'b1, 32'h00000020, 32'h12345678, 1'b0, 32'h00000000, 32'h00000055, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000020, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "a_wr"};
    tbl[3]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000066, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "a_wr_noret"};
    tbl[4]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000043, 32'h00000077, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000040, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "b_rd"};
    tbl[5]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 32'hCAFEF00D, "b_rd_ret"};
    tbl[6]  = '{1'b1, 1'b0, 32'h00000104, 32'h00000999, 1'b1, 32'h00000200, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000104, 32'h00000999, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "a_over_b"};
    tbl[7]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000208, 32'h11111111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000208, 32'h00000000, 1'b1, 32'h11111111, 1'b0, 32'h00000000, "b2b_b"};
    tbl[8]  = '{1'b1, 1'b0, 32'h00000007, 32'h00000000, 1'b0, 32'h00000000, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000004, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 32'h22222222, "b2b_a"};
    tbl[9]  = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000033, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'h00000033, 1'b0, 32'h00000000, "b2b_a_ret"};
    tbl[10] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "wr_hi_addr"};
    tbl[11] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 32'h00000044, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h00000000, "idle"};

    // Reset held with both ports requesting: every output must stay 0.
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h1;
    b_req = 1'b1; b_addr = 32'h20; m_rdata = 32'hFFFFFFFF;
    #12;
    expect_all_zero();
    check_outs("reset");

    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; m_rdata = '0;
    streak = 0; pending = 0;

    // Directed vectors, applied on consecutive cycles.
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].a_req, tbl[i].a_we, tbl[i].a_addr, tbl[i].a_wdata,
             tbl[i].b_req, tbl[i].b_addr, tbl[i].m_rdata);
      e_agnt = tbl[i].agnt;  e_bgnt = tbl[i].bgnt; e_men = tbl[i].men; e_mwe = tbl[i].mwe;
      e_maddr = tbl[i].maddr; e_mwdata = tbl[i].mwdata;
      e_arv = tbl[i].arv; e_ard = tbl[i].ard; e_brv = tbl[i].brv; e_brd = tbl[i].brd;
      check_outs(tbl[i].name);
      tick();
    end

    // Both ports held: B is forced in on every fifth cycle only when enabled.
    for (int i = 0; i < 10; i++) begin
      logic exp_b;
      exp_b = STARVE_EN && ((i % 5) == 4);
      set_in(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h400, 32'h0);
      check($sformatf("starve[%0d].b_gnt", i), 32'(b_gnt), 32'(exp_b));
      check($sformatf("starve[%0d].a_gnt", i), 32'(a_gnt), 32'(!exp_b));
      tick();
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h5);
    tick();

    // Randomized traffic against the model; B is biased toward long requests.
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom % 4) != 0, $urandom % 2, $urandom, $urandom,
             ($urandom % 8) < 5, $urandom, $urandom);
      model_expect();
      check_outs($sformatf("rand[%0d]", i));
      tick();
    end

    // Reset asserted while an A read is in flight: the return is dropped.
    set_in(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    #2;
    reset = 1'b0;
    m_rdata = 32'hABCD1234;
    #1;
    expect_all_zero();
    check_outs("rst_inflight");
    streak = 0; pending = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check_outs("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b0;
    #1;
    model_expect();
    check_outs("rst_release");
    tick();
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h5A5A5A5A);
    model_expect();
    check_outs("rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, consecutive denied cycles of port B before forced grant (range 1..15).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 a_req / a_we  input  1 / 1  core port access request / write enable.
REQ-005 a_addr / a_wdata  input  32 / 32  core port byte address / write data.
REQ-006 a_gnt / a_rvalid  output  1 / 1  core access accepted this cycle / read data valid.
REQ-007 a_rdata  output  32  core port read data.
REQ-008 b_req / b_addr  input  1 / 32  display port read request / byte address; port B is read-only.
REQ-009 b_gnt / b_rvalid / b_rdata  output  1 / 1 / 32  display port grant / read valid / read data.
REQ-010 m_en / m_we  output  1 / 1  memory access strobe / write enable.
REQ-011 m_addr / m_wdata  output  32 / 32  memory word address (bits [1:0] forced 0) / write data.
REQ-012 m_rdata  input  32  memory read data, valid one cycle after an m_en read.

Function
REQ-013 At most one grant per cycle; grants are combinational from the current requests and registered state.
REQ-014 Default priority: a_req wins; b_gnt only when a_req=0 or a forced grant (REQ-019) is active.
REQ-015 Granted cycle: m_en=1; m_addr, m_we, m_wdata from the winner; B cycles drive m_we=0 and m_wdata=0.
REQ-016 No grant: m_en=0, m_we=0, m_addr=0, m_wdata=0.
REQ-017 FSM of the previous cycle's access: IDLE, RD_A, RD_B. A granted read enters RD_A, a B grant enters RD_B, anything else (including A writes) enters IDLE.
REQ-018 In RD_A: a_rvalid=1, a_rdata=m_rdata. In RD_B: b_rvalid=1, b_rdata=m_rdata. Otherwise rvalid=0 and rdata=0; read latency exactly 1 cycle after grant.
REQ-019 Starve counter (4 bits): increments each cycle b_req=1 and b_gnt=0, clears on b_gnt or b_req=0, saturates at 15; when count >= STARVE_MAX, B wins over A that cycle.
REQ-020 Requesters hold req and address stable until gnt; a dropped request is not granted and not remembered.
REQ-021 Back-to-back grants are legal; a grant in RD_x is accepted while the previous data returns.
REQ-022 Simultaneous a_req and b_req with count below threshold: A granted and the B counter increments.

Reset
REQ-023 reset=0 forces FSM to IDLE, the counter to 0, and every output to 0 asynchronously. An in-flight read is discarded and no rvalid follows.
REQ-024 First grant possible on the first rising edge after reset deasserts.

Configuration
REQ-025 Macro DMEM_ARB_STARVE_EN: defined, REQ-019 applies.
REQ-026 Not defined: the counter is not instantiated, priority is strictly A-first, and STARVE_MAX is ignored.

Structure
REQ-027 Shared package dmem_pkg holds the FSM state typedef (arb_state_t), the word-width constant (32), and the counter width (4).
REQ-028 One sub-module, arb_starve_cnt (counter plus threshold compare), is instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-029 Reset, then A read 0x10 with m_rdata=0xDEADBEEF -> a_gnt the same cycle, m_addr=0x10, a_rvalid=1 and a_rdata=0xDEADBEEF the next cycle.
REQ-030 A write 0x20 data 0x12345678 -> m_we=1, m_wdata=0x12345678, no a_rvalid afterward.
REQ-031 B read 0x43 alone -> m_addr=0x40, b_rvalid one cycle later; a_rvalid stays 0.
REQ-032 With STARVE_EN and STARVE_MAX=4, a_req and b_req held continuously -> A granted 4 cycles, B granted in cycle 5, then A resumes.
REQ-033 Same as REQ-032 without the macro -> B never granted while a_req=1.
REQ-034 reset asserted the cycle after an A read grant -> a_rvalid stays 0 and all outputs are 0 immediately.
